md4_share_arbiter: RTL and testbench
====================================

# md4_share_arbiter

Round-robin scheduler that shares one `md4block` instance among `NREQ` cracking lanes, each lane being a password generator/encoder that produces a 512-bit MD4 message block. The arbiter grants one lane at a time, loads the MD4 initial state and the lane's block, and sequences the `md4block` irdy/ordy handshake. It then captures the digest words and returns them to the granted lane with a one-cycle acknowledge. It sits between the per-lane `pwadder`/encoder front ends and the single `md4block`, upstream of the hash checker.

## Interface
- `NREQ`, 4, number of requesting lanes (2..16)
- `IRDY_CYCLES`, 2, cycles `md4_irdy` is held high per trigger (1..7)
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req`  in  NREQ  per-lane request level; held high until that lane's `ack`
- `req_data`  in  NREQ*512  lane i block at `[i*512 +: 512]`, stable while `req[i]` high
- `ack`  out  NREQ  one-hot, one-cycle pulse: result for that lane valid
- `grant_id`  out  $clog2(NREQ)  index of lane currently/last served
- `busy`  out  1  high in every state except IDLE
- `res_a`, `res_b`, `res_c`, `res_d`  out  32 each  digest words (raw md4 state, not byteswapped), valid on `ack`, held until next capture
- `md4_irdy`  out  1  md4block input-ready
- `md4_in_a`..`md4_in_d`  out  32 each  MD4 initial state
- `md4_data`  out  512  message block to md4block
- `md4_ordy`  in  1  md4block output-ready
- `md4_out_a`..`md4_out_d`  in  32 each  md4block result words

## Operation
- States: IDLE, LOAD, TRIG, WAIT, DONE.
- IDLE: if any `req` bit is high, select the winner by round-robin, latch it into `grant_id`, go to LOAD. Otherwise stay.
- Round-robin: search starts at `last+1` mod NREQ and wraps. `last` updates to the winner on grant. After reset `last = NREQ-1`, so lane 0 has highest priority first.
- LOAD: register `md4_data <= req_data[grant_id]` and `md4_in_a..d <= 67452301, efcdab89, 98badcfe, 10325476`. Clear the `armed` flag. Go to TRIG.
- TRIG: `md4_irdy` high for exactly IRDY_CYCLES cycles, counted by a 3-bit counter. Then drop it and go to WAIT.
- WAIT: set `armed` the first cycle `md4_ordy` is sampled low. When `armed` is set and `md4_ordy` is high, capture `md4_out_a..d` into `res_a..d` and go to DONE. A stale high `md4_ordy` left from the previous job is therefore never accepted.
- DONE: `ack[grant_id]` high for this single cycle, then go to IDLE.
- `md4_data` and `md4_in_*` stay constant from LOAD until the next LOAD.
- A lane dropping `req` after grant does not abort the job. The job completes and `ack` is still pulsed.
- A lane dropping `req` before grant is simply not selected.

## Timing
- Reset values: state IDLE, `ack`=0, `md4_irdy`=0, `busy`=0, `grant_id`=0, `res_*`=0, `md4_in_*`=0, `md4_data`=0, `armed`=0, `last`=NREQ-1.
- Reset asserted mid-job: the next edge returns to IDLE with reset values. The in-flight md4 result is discarded and no `ack` is issued.
- With `req` first seen high in IDLE at edge t:
  - LOAD at t+1.
  - `md4_irdy` high for cycles t+2 .. t+1+IRDY_CYCLES.
  - WAIT from t+2+IRDY_CYCLES.
  - Result captured at the first edge with `armed`=1 and `md4_ordy`=1.
  - `ack` high during the following cycle.
- Overhead beyond md4block latency: 4 + IRDY_CYCLES cycles per job. Back-to-back grants are possible: IDLE to LOAD in one cycle after DONE.
- Requester rule: on seeing `ack[i]` high, deassert `req[i]` so that it is low when sampled in the following IDLE cycle. Otherwise lane i is treated as a new request, subject to round-robin order.
- Simultaneous `req` rising in IDLE on several lanes: exactly one grant, chosen by pointer order.
- `busy` is registered and equals (state != IDLE).

## Test plan
- Single lane: `req`=4'b0001 with data = encoded "a" block -> `md4_irdy` high exactly 2 cycles, LOAD drives `md4_in_*`=67452301/efcdab89/98badcfe/10325476. When md4block returns, `ack`=4'b0001 for one cycle and `res_a..d` equal the md4block outputs.
- Fairness: all four `req` held high continuously, each re-raised after its `ack` -> grant order 0,1,2,3,0,1 with no lane served twice in a row.
- Stale ordy: hold `md4_ordy` high from the previous job into WAIT for 3 cycles, then low 1 cycle, then high -> capture occurs only after the low cycle.
- Reset mid-job: assert `rst_n`=0 for one cycle during WAIT -> no `ack`, outputs at reset values, and lane 0 is granted first afterwards.
- Request withdrawal: lane 2 raises `req` then drops it before grant while lane 1 is being served -> lane 2 never acked. Lane 3 drops `req` after its grant -> `ack`=4'b1000 still pulses.
- IRDY_CYCLES=1, NREQ=2: verify `md4_irdy` high 1 cycle and overhead of 5 cycles per job.

Source files
------------

// File: rtl/md4_share_arbiter.sv
// md4_share_arbiter
// Round-robin scheduler that time-shares one md4block among NREQ cracking
// lanes. A granted lane's 512-bit block is loaded with the MD4 initial state,
// md4block is triggered through irdy, and the digest is captured once a fresh
// ordy is seen. The digest goes back to the lane with a one-cycle ack.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req[NREQ]                  per-lane request level
//   req_data[NREQ*512]         lane i block at [i*512 +: 512]
//   ack[NREQ]                  one-hot, one-cycle result-valid pulse
//   grant_id                   lane currently / last served
//   busy                       registered, high whenever not IDLE
//   res_a..res_d               captured digest words (raw MD4 state)
//   md4_irdy                   md4block input-ready
//   md4_in_a..md4_in_d         MD4 initial state to md4block
//   md4_data                   message block to md4block
//   md4_ordy                   md4block output-ready
//   md4_out_a..md4_out_d       md4block result words
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no job; grant the round-robin winner when any req is high
// LOAD  | latch the winner's block and the MD4 initial state
// TRIG  | hold md4_irdy high for IRDY_CYCLES cycles
// WAIT  | arm on a low ordy, then capture the digest on a high ordy
// DONE  | pulse ack for the granted lane
module md4_share_arbiter #(
  parameter int NREQ        = 4,
  parameter int IRDY_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*512-1:0]      req_data,
  output logic [NREQ-1:0]          ack,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic [31:0]              res_a,
  output logic [31:0]              res_b,
  output logic [31:0]              res_c,
  output logic [31:0]              res_d,
  output logic                     md4_irdy,
  output logic [31:0]              md4_in_a,
  output logic [31:0]              md4_in_b,
  output logic [31:0]              md4_in_c,
  output logic [31:0]              md4_in_d,
  output logic [511:0]             md4_data,
  input  logic                     md4_ordy,
  input  logic [31:0]              md4_out_a,
  input  logic [31:0]              md4_out_b,
  input  logic [31:0]              md4_out_c,
  input  logic [31:0]              md4_out_d
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_TRIG = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] last;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic           any_req;
  logic [2:0]     trig_cnt;
  logic           armed;

  // Round-robin pick: scan from last+1 upward with wrap. The loop runs from
  // the farthest offset down so the nearest requesting lane is written last.
  always_comb begin
    winner  = last;
    any_req = 1'b0;
    idx     = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = IDW'((int'(last) + off) % NREQ);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  // State register; busy is registered from the next state so it tracks
  // (state != IDLE) without a decode after the flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_TRIG;
      S_TRIG:  if (trig_cnt == 3'd0) state_nxt = S_WAIT;
      S_WAIT:  if (armed && md4_ordy) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    md4_irdy = (state == S_TRIG);
    ack      = '0;
    if (state == S_DONE) ack[grant_id] = 1'b1;
  end

  // Datapath. trig_cnt is a down-counter loaded in LOAD; TRIG ends at zero.
  // armed guards against an ordy that is still high from the previous job.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_id <= '0;
      last     <= IDW'(NREQ - 1);
      trig_cnt <= '0;
      armed    <= 1'b0;
      res_a    <= '0;
      res_b    <= '0;
      res_c    <= '0;
      res_d    <= '0;
      md4_in_a <= '0;
      md4_in_b <= '0;
      md4_in_c <= '0;
      md4_in_d <= '0;
      md4_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant_id <= winner;
            last     <= winner;
          end
        end
        S_LOAD: begin
          md4_data <= req_data[int'(grant_id)*512 +: 512];
          md4_in_a <= 32'h6745_2301;
          md4_in_b <= 32'hefcd_ab89;
          md4_in_c <= 32'h98ba_dcfe;
          md4_in_d <= 32'h1032_5476;
          trig_cnt <= 3'(IRDY_CYCLES - 1);
          armed    <= 1'b0;
        end
        S_TRIG: begin
          if (trig_cnt != 3'd0) trig_cnt <= trig_cnt - 3'd1;
        end
        S_WAIT: begin
          if (!md4_ordy) armed <= 1'b1;
          if (armed && md4_ordy) begin
            res_a <= md4_out_a;
            res_b <= md4_out_b;
            res_c <= md4_out_c;
            res_d <= md4_out_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md4_share_arbiter.sv
module tb_md4_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [3:0]    req;
  logic [2047:0] req_data;
  logic [3:0]    ack;
  logic [1:0]    grant_id;
  logic          busy;
  logic [31:0]   res_a, res_b, res_c, res_d;
  logic          irdy;
  logic [31:0]   in_a, in_b, in_c, in_d;
  logic [511:0]  md4_data;
  logic          ordy;
  logic [31:0]   out_a, out_b, out_c, out_d;

  md4_share_arbiter #(.NREQ(4), .IRDY_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .grant_id(grant_id), .busy(busy),
    .res_a(res_a), .res_b(res_b), .res_c(res_c), .res_d(res_d),
    .md4_irdy(irdy), .md4_in_a(in_a), .md4_in_b(in_b), .md4_in_c(in_c),
    .md4_in_d(in_d), .md4_data(md4_data), .md4_ordy(ordy),
    .md4_out_a(out_a), .md4_out_b(out_b), .md4_out_c(out_c), .md4_out_d(out_d)
  );

  logic [1:0]    b_req;
  logic [1023:0] b_req_data;
  logic [1:0]    b_ack;
  logic [0:0]    b_grant_id;
  logic          b_busy;
  logic [31:0]   b_res_a, b_res_b, b_res_c, b_res_d;
  logic          b_irdy;
  logic [31:0]   b_in_a, b_in_b, b_in_c, b_in_d;
  logic [511:0]  b_md4_data;
  logic          b_ordy;
  logic [31:0]   b_out_a, b_out_b, b_out_c, b_out_d;

  md4_share_arbiter #(.NREQ(2), .IRDY_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(b_req), .req_data(b_req_data), .ack(b_ack),
    .grant_id(b_grant_id), .busy(b_busy),
    .res_a(b_res_a), .res_b(b_res_b), .res_c(b_res_c), .res_d(b_res_d),
    .md4_irdy(b_irdy), .md4_in_a(b_in_a), .md4_in_b(b_in_b), .md4_in_c(b_in_c),
    .md4_in_d(b_in_d), .md4_data(b_md4_data), .md4_ordy(b_ordy),
    .md4_out_a(b_out_a), .md4_out_b(b_out_b), .md4_out_c(b_out_c), .md4_out_d(b_out_d)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [127:0] prev_res;
  int order [6] = '{0, 1, 2, 3, 0, 1};

  localparam logic [127:0] MD4_IV    = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
  localparam logic [127:0] MD4_A_RES = {32'hb32ce5bd, 32'h463ee31d, 32'hfb055e24, 32'h4ab26fdb};

  // Lane 0 carries the padded MD4 block for "a"; other lanes get distinct filler.
  function automatic logic [511:0] blk(input int lane);
    logic [511:0] b;
    b = '0;
    if (lane == 0) begin
      b[31:0]    = 32'h0000_8061;
      b[14*32 +: 32] = 32'h0000_0008;
    end else begin
      for (int k = 0; k < 16; k++) b[k*32 +: 32] = 32'h1000_0000 * lane + k;
    end
    return b;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plays md4block for one job on the 4-lane instance. Entered with the job's
  // request already raised; returns at the DONE cycle with the lane's req dropped.
  task automatic do_job(input logic [127:0] digest, input bit stale, input string tag,
                        output int gid, output logic [3:0] ack_seen);
    int guard;
    int n_hi;
    guard = 0;
    while (!irdy && guard < 12) begin step(); guard++; end
    chk({tag, " irdy_rise"}, irdy, 1'b1);
    if (!stale) ordy = 1'b0;
    n_hi = 0;
    while (irdy && n_hi < 10) begin n_hi++; step(); end
    chk({tag, " irdy_len"}, n_hi, 2);
    if (stale) begin
      for (int k = 0; k < 3; k++) begin
        chk({tag, " stale_noack"}, ack, 4'b0000);
        chk({tag, " stale_res_held"}, {res_a, res_b, res_c, res_d}, prev_res);
        step();
      end
    end
    ordy = 1'b0;
    step();
    {out_a, out_b, out_c, out_d} = digest;
    ordy = 1'b1;
    guard = 0;
    step();
    while (ack == 4'b0000 && guard < 10) begin step(); guard++; end
    chk({tag, " capture_latency"}, guard, 0);
    chk({tag, " res"}, {res_a, res_b, res_c, res_d}, digest);
    prev_res = digest;
    gid      = int'(grant_id);
    ack_seen = ack;
    req[grant_id] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid;
    logic [3:0] acks;
    int guard;

    rst_n = 1'b0; req = '0; ordy = 1'b0;
    {out_a, out_b, out_c, out_d} = '0;
    for (int i = 0; i < 4; i++) req_data[i*512 +: 512] = blk(i);
    b_req = '0; b_ordy = 1'b0;
    {b_out_a, b_out_b, b_out_c, b_out_d} = '0;
    for (int i = 0; i < 2; i++) b_req_data[i*512 +: 512] = blk(i + 4);
    prev_res = '0;

    // Reset state
    step(); step();
    chk("rst ack", ack, 4'b0000);
    chk("rst busy", busy, 1'b0);
    chk("rst grant_id", grant_id, 2'd0);
    chk("rst irdy", irdy, 1'b0);
    chk("rst res", {res_a, res_b, res_c, res_d}, 128'd0);
    chk("rst md4_in", {in_a, in_b, in_c, in_d}, 128'd0);
    chk("rst md4_data", md4_data, 512'd0);
    rst_n = 1'b1;
    step();

    // Single lane, cycle by cycle
    req = 4'b0001;
    step();
    chk("single LOAD busy", busy, 1'b1);
    chk("single LOAD grant", grant_id, 2'd0);
    chk("single LOAD irdy", irdy, 1'b0);
    step();
    chk("single TRIG1 irdy", irdy, 1'b1);
    chk("single md4_in", {in_a, in_b, in_c, in_d}, MD4_IV);
    chk("single md4_data", md4_data, blk(0));
    step();
    chk("single TRIG2 irdy", irdy, 1'b1);
    step();
    chk("single WAIT irdy", irdy, 1'b0);
    chk("single WAIT busy", busy, 1'b1);
    step();
    chk("single armed noack", ack, 4'b0000);
    {out_a, out_b, out_c, out_d} = MD4_A_RES;
    ordy = 1'b1;
    step();
    chk("single ack", ack, 4'b0001);
    chk("single res", {res_a, res_b, res_c, res_d}, MD4_A_RES);
    req = 4'b0000;
    step();
    chk("single ack pulse", ack, 4'b0000);
    chk("single idle busy", busy, 1'b0);
    chk("single res held", {res_a, res_b, res_c, res_d}, MD4_A_RES);
    prev_res = MD4_A_RES;

    // Fairness from a fresh pointer; job 2 sees a stale ordy
    rst_n = 1'b0; step(); rst_n = 1'b1;
    prev_res = '0;
    req = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      do_job({32'ha0000000 + j, 32'hb0000000 + j, 32'hc0000000 + j, 32'hd0000000 + j},
             (j == 2), "fair", gid, acks);
      chk("fair gid", gid, order[j]);
      chk("fair ack", acks, 4'b0001 << order[j]);
      step();
      if (j < 5) req[gid] = 1'b1;
    end
    req = 4'b0000;
    step();

    // Reset during WAIT: no ack, reset values, lane 0 first afterwards
    req = 4'b0100;
    ordy = 1'b0;
    guard = 0;
    while (!irdy && guard < 12) begin step(); guard++; end
    guard = 0;
    while (irdy && guard < 12) begin step(); guard++; end
    chk("midrst reached WAIT", busy, 1'b1);
    step();
    rst_n = 1'b0;
    ordy = 1'b1;
    {out_a, out_b, out_c, out_d} = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    step();
    chk("midrst busy", busy, 1'b0);
    chk("midrst ack", ack, 4'b0000);
    chk("midrst irdy", irdy, 1'b0);
    chk("midrst res", {res_a, res_b, res_c, res_d}, 128'd0);
    chk("midrst md4_in", {in_a, in_b, in_c, in_d}, 128'd0);
    chk("midrst md4_data", md4_data, 512'd0);
    chk("midrst grant", grant_id, 2'd0);
    rst_n = 1'b1;
    prev_res = '0;
    req = 4'b0101;
    do_job(128'h11111111_22222222_33333333_44444444, 1'b0, "postrst", gid, acks);
    chk("postrst gid", gid, 0);
    chk("postrst ack", acks, 4'b0001);
    step();
    do_job(128'h55555555_66666666_77777777_88888888, 1'b0, "postrst2", gid, acks);
    chk("postrst2 gid", gid, 2);
    chk("postrst2 ack", acks, 4'b0100);
    step();

    // Withdrawal: lane 2 drops before grant, lane 3 drops after grant
    req = 4'b0110;
    step();
    chk("withdraw grant", grant_id, 2'd1);
    req[2] = 1'b0;
    do_job(128'h0a0a0a0a_0b0b0b0b_0c0c0c0c_0d0d0d0d, 1'b0, "withdraw", gid, acks);
    chk("withdraw gid", gid, 1);
    chk("withdraw ack", acks, 4'b0010);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("withdraw lane2 idle", busy, 1'b0);
      chk("withdraw lane2 noack", ack, 4'b0000);
      step();
    end
    req = 4'b1000;
    step();
    chk("late drop grant", grant_id, 2'd3);
    req[3] = 1'b0;
    do_job(128'hcafef00d_12345678_9abcdef0_0f1e2d3c, 1'b0, "latedrop", gid, acks);
    chk("latedrop gid", gid, 3);
    chk("latedrop ack", acks, 4'b1000);
    step();
    chk("latedrop idle", busy, 1'b0);

    // NREQ=2, IRDY_CYCLES=1: one irdy cycle, ack 5 cycles after grant edge
    b_req = 2'b01;
    step();
    chk("n2 LOAD busy", b_busy, 1'b1);
    chk("n2 LOAD grant", b_grant_id, 1'b0);
    chk("n2 LOAD irdy", b_irdy, 1'b0);
    step();
    chk("n2 TRIG irdy", b_irdy, 1'b1);
    chk("n2 md4_data", b_md4_data, blk(4));
    step();
    chk("n2 WAIT irdy", b_irdy, 1'b0);
    step();
    chk("n2 armed noack", b_ack, 2'b00);
    b_ordy = 1'b1;
    {b_out_a, b_out_b, b_out_c, b_out_d} = 128'h01020304_05060708_090a0b0c_0d0e0f10;
    step();
    chk("n2 ack lane0", b_ack, 2'b01);
    chk("n2 res lane0", {b_res_a, b_res_b, b_res_c, b_res_d}, 128'h01020304_05060708_090a0b0c_0d0e0f10);
    b_req = 2'b10;
    step();
    chk("n2 idle ack", b_ack, 2'b00);
    chk("n2 idle busy", b_busy, 1'b0);
    step();
    chk("n2 grant lane1", b_grant_id, 1'b1);
    step();
    chk("n2 TRIG2 irdy", b_irdy, 1'b1);
    step();
    chk("n2 WAIT2 irdy", b_irdy, 1'b0);
    b_ordy = 1'b0;
    step();
    chk("n2 stale noack", b_ack, 2'b00);
    b_ordy = 1'b1;
    {b_out_a, b_out_b, b_out_c, b_out_d} = 128'hf0e0d0c0_b0a09080_70605040_30201000;
    step();
    chk("n2 ack lane1", b_ack, 2'b10);
    chk("n2 res lane1", {b_res_a, b_res_b, b_res_c, b_res_d}, 128'hf0e0d0c0_b0a09080_70605040_30201000);
    b_req = 2'b00;
    step();
    chk("n2 final idle", b_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
